if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/if_stage.sv | 93 +++++++++
 tb/tb_if_stage.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the IF, ID and CSR stages: fetch NOP,
// exception-code width and the synchronous exception-code constants.
package cpu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned EXC_CODE_W = 4;

    typedef logic [XLEN-1:0]       word_t;
    typedef logic [EXC_CODE_W-1:0] exc_code_t;

    // addi x0, x0, 0
    localparam word_t CPU_NOP_INST = 32'h0000_0013;

    localparam exc_code_t EXC_CODE_IADDR_MISALIGN = 4'd0;
    localparam exc_code_t EXC_CODE_IACCESS_FAULT  = 4'd1;
    localparam exc_code_t EXC_CODE_ILLEGAL_INST   = 4'd2;
    localparam exc_code_t EXC_CODE_BREAKPOINT     = 4'd3;
    localparam exc_code_t EXC_CODE_ECALL_M        = 4'd11;

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues the synchronous imem read for the next PC and
// presents the returned instruction to ID. Optional IF_INST_BUF_EN adds a stall buffer.
module if_stage
    import cpu_pkg::*;
#(
    parameter word_t     NOP_INST           = CPU_NOP_INST,
    parameter exc_code_t EXC_IADDR_MISALIGN = EXC_CODE_IADDR_MISALIGN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           din,
    input  logic [31:0]           pc,
    input  logic                  pre_if_valid,
    input  logic                  id_allow_in,
    input  logic                  flush,
    input  logic [31:0]           imem_rdata,
    output logic                  if_allow_in,
    output logic                  imem_en,
    output logic [31:0]           imem_addr,
    output logic                  if_to_id_valid,
    output logic [31:0]           if_to_id_pc,
    output logic [31:0]           if_to_id_inst,
    output logic                  if_to_id_exc,
    output logic [EXC_CODE_W-1:0] if_to_id_exc_code
);

    logic  if_valid;
    logic  exc_r;
    logic  accept;
    logic  aligned;
    logic  hand_off;
    word_t fetched_inst;

    assign aligned     = (din[1:0] == 2'b00);
    assign if_allow_in = ~rst_n | ~if_valid | id_allow_in | flush;
    assign accept      = rst_n & if_allow_in & pre_if_valid;
    assign hand_off    = if_valid & id_allow_in;

    assign imem_addr   = din;
    assign imem_en     = accept & aligned;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_valid <= 1'b0;
            exc_r    <= 1'b0;
        end else if (accept) begin
            if_valid <= pre_if_valid;
            exc_r    <= ~aligned;
        end else if (flush || hand_off) begin
            if_valid <= 1'b0;
        end
    end

`ifdef IF_INST_BUF_EN
    logic  buf_valid;
    word_t inst_buf;

    // Capture once per stall so a memory that drifts while disabled cannot
    // disturb the instruction ID is waiting on.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
        end else if (accept || flush || hand_off) begin
            buf_valid <= 1'b0;
        end else if (if_valid && !buf_valid) begin
            buf_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && if_valid && !buf_valid && !accept && !flush && !hand_off) begin
            inst_buf <= imem_rdata;
        end
    end

    assign fetched_inst = buf_valid ? inst_buf : imem_rdata;
`else
    assign fetched_inst = imem_rdata;
`endif

    assign if_to_id_valid    = rst_n & if_valid & ~flush;
    assign if_to_id_pc       = pc;
    assign if_to_id_exc      = rst_n & exc_r;
    assign if_to_id_exc_code = (rst_n && exc_r) ? EXC_IADDR_MISALIGN : '0;

    always_comb begin
        if_to_id_inst = fetched_inst;
        if (!rst_n || exc_r) begin
            if_to_id_inst = NOP_INST;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed scenarios followed by randomized
// fetch/stall/flush/reset traffic checked against a queue-based fetch model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] din;
    logic [31:0] pc;
    logic        pre_if_valid;
    logic        id_allow_in;
    logic        flush;
    logic [31:0] imem_rdata;
    logic        if_allow_in;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic        if_to_id_valid;
    logic [31:0] if_to_id_pc;
    logic [31:0] if_to_id_inst;
    logic        if_to_id_exc;
    logic [3:0]  if_to_id_exc_code;

    localparam logic [31:0] NOP = 32'h0000_0013;

    if_stage #(.NOP_INST(32'h0000_0013), .EXC_IADDR_MISALIGN(4'd0)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .din               (din),
        .pc                (pc),
        .pre_if_valid      (pre_if_valid),
        .id_allow_in       (id_allow_in),
        .flush             (flush),
        .imem_rdata        (imem_rdata),
        .if_allow_in       (if_allow_in),
        .imem_en           (imem_en),
        .imem_addr         (imem_addr),
        .if_to_id_valid    (if_to_id_valid),
        .if_to_id_pc       (if_to_id_pc),
        .if_to_id_inst     (if_to_id_inst),
        .if_to_id_exc      (if_to_id_exc),
        .if_to_id_exc_code (if_to_id_exc_code)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    // Synchronous instruction memory that holds its output while disabled.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem_word(imem_addr);
    end

    // PC register enabled by if_allow_in; reset value is deliberately not a fetch target.
    always @(posedge clk) begin
        if (!rst_n) pc <= 32'hFFFF_FFF0;
        else if (if_allow_in && pre_if_valid) pc <= din;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: at the negedge the inputs for the coming edge are stable and the
    // queue describes what IF should be holding right now.
    always @(negedge clk) begin : mon
        logic occupied;
        logic allow;
        logic acc;
        exp_t e;
        if (!rst_n) begin
            chk("rst_valid", 32'(if_to_id_valid), 32'd0);
            chk("rst_exc", 32'(if_to_id_exc), 32'd0);
            chk("rst_code", 32'(if_to_id_exc_code), 32'd0);
            chk("rst_inst", if_to_id_inst, NOP);
            chk("rst_allow", 32'(if_allow_in), 32'd1);
            chk("rst_imem_en", 32'(imem_en), 32'd0);
            q.delete();
        end else begin
            occupied = (q.size() != 0);
            allow    = !occupied || id_allow_in || flush;
            acc      = allow && pre_if_valid;
            chk("allow", 32'(if_allow_in), 32'(allow));
            chk("imem_en", 32'(imem_en), 32'(acc && din[1:0] == 2'b00));
            if (imem_en) chk("imem_addr", imem_addr, din);
            chk("valid", 32'(if_to_id_valid), 32'(occupied && !flush));
            if (occupied && !flush && if_to_id_valid) begin
                e = q[0];
                chk("pc", if_to_id_pc, e.pc);
                chk("inst", if_to_id_inst, e.inst);
                chk("exc", 32'(if_to_id_exc), 32'(e.exc));
                if (e.exc) chk("exc_code", 32'(if_to_id_exc_code), 32'd0);
            end
            if (occupied && (flush || id_allow_in)) void'(q.pop_front());
            if (acc) begin
                e.pc   = din;
                e.exc  = (din[1:0] != 2'b00);
                e.inst = e.exc ? NOP : mem_word(din);
                q.push_back(e);
            end
        end
    end

    task automatic step(input logic pv, input logic [31:0] d, input logic ida,
                        input logic fl, input logic rn);
        pre_if_valid = pv;
        din          = d;
        id_allow_in  = ida;
        flush        = fl;
        rst_n        = rn;
        @(posedge clk);
        #1;
    endtask

    initial begin : drv
        logic [31:0] next_pc;
        logic [31:0] stall_inst;
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        // Simple fetch, then streaming 0,4,8 with no bubble
        step(1, 32'h0, 1, 0, 1);
        step(1, 32'h4, 1, 0, 1);
        step(1, 32'h8, 1, 0, 1);
        step(1, 32'hC, 1, 0, 1);
        step(1, 32'h0, 1, 0, 1);
        // Fetch 4 and stall it for three cycles
        step(1, 32'h4, 1, 0, 1);
        stall_inst = if_to_id_inst;
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h8, 0, 0, 1);
            chk("stall_pc", pc, 32'h4);
            chk("stall_inst", if_to_id_inst, stall_inst);
        end
        // Flush to 0x100 while stalled
        step(1, 32'h100, 0, 1, 1);
        chk("flush_pc", if_to_id_pc, 32'h100);
        // Misaligned fetch
        step(1, 32'h102, 1, 0, 1);
        step(1, 32'h200, 0, 0, 1);
        chk("misalign_inst", if_to_id_inst, NOP);
        chk("misalign_exc", 32'(if_to_id_exc), 32'd1);
        // Reset asserted mid-stall, then first fetch after release
        step(1, 32'h200, 0, 0, 1);
        step(1, 32'h204, 0, 0, 0);
        chk("rst_mid_valid", 32'(if_to_id_valid), 32'd0);
        step(1, 32'h300, 1, 0, 1);
        chk("post_rst_pc", if_to_id_pc, 32'h300);

        next_pc = 32'h304;
        for (int i = 0; i < 3000; i++) begin
            logic        fl;
            logic        rn;
            logic [31:0] d;
            fl = ($urandom_range(0, 9) == 0);
            rn = ($urandom_range(0, 99) != 0);
            d  = fl ? {16'h0, $urandom_range(0, 16'hFFFF)} & 32'hFFFF_FFFC : next_pc;
            if ($urandom_range(0, 9) == 0) d = d | 32'($urandom_range(1, 3));
            step(($urandom_range(0, 4) != 0), d, ($urandom_range(0, 9) < 7), fl, rn);
            if (if_allow_in && pre_if_valid) next_pc = (d & 32'hFFFF_FFFC) + 32'd4;
        end
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
